// File: rtl/axi_lite_sram_slave.sv
// axi_lite_sram_slave: AXI4-Lite slave in front of a word-addressed SRAM array.
// Independent write (AW/W/B) and read (AR/R) FSMs; all outputs registered.
// Optional macro AXI_SLAVE_LAT_EN adds WR_LAT / RD_LAT response wait states.
//
// Write FSM
//   state   | meaning
//   W_IDLE  | collecting AW and W (either order); commits once both are latched
//   W_DELAY | (AXI_SLAVE_LAT_EN) response wait, down-counter running
//   W_RESP  | BVALID held until BREADY
//
// Read FSM
//   state   | meaning
//   R_IDLE  | ARREADY high, waiting for an address
//   R_DELAY | (AXI_SLAVE_LAT_EN) response wait, data already captured
//   R_DATA  | RVALID held until RREADY
module axi_lite_sram_slave #(
    parameter int unsigned       DWIDTH     = 32,
    parameter int unsigned       AWIDTH     = 64,
    parameter int unsigned       DEPTH_LOG2 = 10,
    parameter logic [AWIDTH-1:0] BASE_ADDR  = 64'h8000_0000,
    parameter int                RD_LAT     = 2,
    parameter int                WR_LAT     = 2
) (
    input  logic                ACLK,
    input  logic                ARESTn,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [AWIDTH-1:0]   AWADDR,
    input  logic                WVALID,
    output logic                WREADY,
    input  logic [DWIDTH-1:0]   WDATA,
    input  logic [DWIDTH/8-1:0] WSTRB,
    output logic                BVALID,
    input  logic                BREADY,
    output logic [1:0]          BRESP,
    input  logic                ARVALID,
    output logic                ARREADY,
    input  logic [AWIDTH-1:0]   ARADDR,
    output logic                RVALID,
    input  logic                RREADY,
    output logic [DWIDTH-1:0]   RDATA,
    output logic [1:0]          RRESP
);

    localparam int unsigned BYTES    = DWIDTH / 8;
    localparam int unsigned OFF_BITS = $clog2(BYTES);
    localparam int unsigned DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [AWIDTH-1:0] END_ADDR =
        BASE_ADDR + (AWIDTH'(1) << (DEPTH_LOG2 + OFF_BITS));
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef AXI_SLAVE_LAT_EN
    localparam int WCW = $clog2((WR_LAT > 1) ? WR_LAT : 1) + 1;
    localparam int RCW = $clog2((RD_LAT > 1) ? RD_LAT : 1) + 1;
    typedef enum logic [1:0] {W_IDLE, W_RESP, W_DELAY} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_DELAY} r_state_t;
`else
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
`endif

    function automatic logic addr_in_range(input logic [AWIDTH-1:0] a);
        return (a >= BASE_ADDR) && (a < END_ADDR);
    endfunction

    // Byte offset bits drop out in the shift; upper bits are truncated.
    function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [AWIDTH-1:0] a);
        return DEPTH_LOG2'((a - BASE_ADDR) >> OFF_BITS);
    endfunction

    logic [DWIDTH-1:0] mem [DEPTH];

    // ---------------- write path ----------------
    w_state_t            w_state, w_state_n;
    logic                aw_lat_q, aw_lat_n;
    logic                w_lat_q, w_lat_n;
    logic [AWIDTH-1:0]   aw_addr_q, aw_addr_n;
    logic [DWIDTH-1:0]   wdata_q, wdata_n;
    logic [BYTES-1:0]    wstrb_q, wstrb_n;
    logic                awready_q, awready_n;
    logic                wready_q, wready_n;
    logic                bvalid_q, bvalid_n;
    logic [1:0]          bresp_q, bresp_n;
    logic                mem_we;
    logic                wr_hit;
    logic [DEPTH_LOG2-1:0] wr_idx;
`ifdef AXI_SLAVE_LAT_EN
    logic [WCW-1:0]      wcnt_q, wcnt_n;
`endif

    assign wr_hit = addr_in_range(aw_addr_q);
    assign wr_idx = addr_idx(aw_addr_q);

    // Write FSM next-state and next-output logic.
    always_comb begin
        w_state_n = w_state;
        aw_lat_n  = aw_lat_q;
        w_lat_n   = w_lat_q;
        aw_addr_n = aw_addr_q;
        wdata_n   = wdata_q;
        wstrb_n   = wstrb_q;
        awready_n = awready_q;
        wready_n  = wready_q;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        mem_we    = 1'b0;
`ifdef AXI_SLAVE_LAT_EN
        wcnt_n    = wcnt_q;
`endif
        case (w_state)
            W_IDLE: begin
                if (aw_lat_q && w_lat_q) begin
                    mem_we  = wr_hit;
                    bresp_n = wr_hit ? RESP_OKAY : RESP_DECERR;
`ifdef AXI_SLAVE_LAT_EN
                    if (WR_LAT == 0) begin
                        bvalid_n  = 1'b1;
                        w_state_n = W_RESP;
                    end else begin
                        wcnt_n    = WCW'(WR_LAT - 1);
                        w_state_n = W_DELAY;
                    end
`else
                    bvalid_n  = 1'b1;
                    w_state_n = W_RESP;
`endif
                end else begin
                    if (AWVALID && awready_q) begin
                        aw_lat_n  = 1'b1;
                        aw_addr_n = AWADDR;
                        awready_n = 1'b0;
                    end
                    if (WVALID && wready_q) begin
                        w_lat_n  = 1'b1;
                        wdata_n  = WDATA;
                        wstrb_n  = WSTRB;
                        wready_n = 1'b0;
                    end
                end
            end
`ifdef AXI_SLAVE_LAT_EN
            W_DELAY: begin
                if (wcnt_q == '0) begin
                    bvalid_n  = 1'b1;
                    w_state_n = W_RESP;
                end else begin
                    wcnt_n = wcnt_q - 1'b1;
                end
            end
`endif
            W_RESP: begin
                if (BREADY) begin
                    bvalid_n  = 1'b0;
                    aw_lat_n  = 1'b0;
                    w_lat_n   = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    // Write FSM state and output registers.
    always_ff @(posedge ACLK or negedge ARESTn) begin
        if (!ARESTn) begin
            w_state   <= W_IDLE;
            aw_lat_q  <= 1'b0;
            w_lat_q   <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
`ifdef AXI_SLAVE_LAT_EN
            wcnt_q    <= '0;
`endif
        end else begin
            w_state   <= w_state_n;
            aw_lat_q  <= aw_lat_n;
            w_lat_q   <= w_lat_n;
            aw_addr_q <= aw_addr_n;
            wdata_q   <= wdata_n;
            wstrb_q   <= wstrb_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
`ifdef AXI_SLAVE_LAT_EN
            wcnt_q    <= wcnt_n;
`endif
        end
    end

    // Array write with byte-lane enables; contents survive reset.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wstrb_q[i]) mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t            r_state, r_state_n;
    logic                arready_q, arready_n;
    logic                rvalid_q, rvalid_n;
    logic [DWIDTH-1:0]   rdata_q, rdata_n;
    logic [1:0]          rresp_q, rresp_n;
    logic                rd_hit;
`ifdef AXI_SLAVE_LAT_EN
    logic [RCW-1:0]      rcnt_q, rcnt_n;
`endif

    assign rd_hit = addr_in_range(ARADDR);

    // Read FSM next-state and next-output logic; the array is sampled before
    // any same-edge write lands, giving read-before-write on collisions.
    always_comb begin
        r_state_n = r_state;
        arready_n = arready_q;
        rvalid_n  = rvalid_q;
        rdata_n   = rdata_q;
        rresp_n   = rresp_q;
`ifdef AXI_SLAVE_LAT_EN
        rcnt_n    = rcnt_q;
`endif
        case (r_state)
            R_IDLE: begin
                if (ARVALID && arready_q) begin
                    rdata_n   = rd_hit ? mem[addr_idx(ARADDR)] : '0;
                    rresp_n   = rd_hit ? RESP_OKAY : RESP_DECERR;
                    arready_n = 1'b0;
`ifdef AXI_SLAVE_LAT_EN
                    if (RD_LAT == 0) begin
                        rvalid_n  = 1'b1;
                        r_state_n = R_DATA;
                    end else begin
                        rcnt_n    = RCW'(RD_LAT - 1);
                        r_state_n = R_DELAY;
                    end
`else
                    rvalid_n  = 1'b1;
                    r_state_n = R_DATA;
`endif
                end
            end
`ifdef AXI_SLAVE_LAT_EN
            R_DELAY: begin
                if (rcnt_q == '0) begin
                    rvalid_n  = 1'b1;
                    r_state_n = R_DATA;
                end else begin
                    rcnt_n = rcnt_q - 1'b1;
                end
            end
`endif
            R_DATA: begin
                if (RREADY) begin
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                    r_state_n = R_IDLE;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    // Read FSM state and output registers.
    always_ff @(posedge ACLK or negedge ARESTn) begin
        if (!ARESTn) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
`ifdef AXI_SLAVE_LAT_EN
            rcnt_q    <= '0;
`endif
        end else begin
            r_state   <= r_state_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rdata_q   <= rdata_n;
            rresp_q   <= rresp_n;
`ifdef AXI_SLAVE_LAT_EN
            rcnt_q    <= rcnt_n;
`endif
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

endmodule
